// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - EX/CSR to PC controller signal bundle
interface pc_redirect_ctrl_if;
  logic [2:0]  pc_sel;
  logic        stall;
  logic [31:0] jalr_tgt;
  logic [31:0] branch_tgt;
  logic [31:0] jal_tgt;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flushed;
  logic        int_ack;
  logic        misaligned;

  modport master (
    output pc_sel, stall, jalr_tgt, branch_tgt, jal_tgt, mtvec, mepc,
    input  pc, pc_plus4, flushed, int_ack, misaligned
  );

  modport slave (
    input  pc_sel, stall, jalr_tgt, branch_tgt, jal_tgt, mtvec, mepc,
    output pc, pc_plus4, flushed, int_ack, misaligned
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - next-PC select, stall hold and wrong-path flush window
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  pc_redirect_ctrl_if.slave bus
);

  localparam logic [2:0] DEPTH = 3'(FLUSH_DEPTH);

  logic [31:0] pc_q;
  logic [31:0] target;
  logic        redirect;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic        flushed_q;
  logic        int_ack_q;
  logic        misaligned_q;

  always_comb begin
    redirect = 1'b1;
    target   = '0;
    case (bus.pc_sel)
      3'b001:  target = {bus.jalr_tgt[31:1], 1'b0};
      3'b010:  target = bus.branch_tgt;
      3'b011:  target = bus.jal_tgt;
      3'b100:  target = bus.mtvec;
      3'b101:  target = bus.mepc;
      default: redirect = 1'b0;
    endcase
  end

  // A redirect always reloads the window; stalls freeze it so squashing covers the held slot.
  always_comb begin
    cnt_d = cnt_q;
    if (redirect) begin
      cnt_d = DEPTH;
    end else if (cnt_q != 3'd0 && !bus.stall) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_VEC;
      cnt_q        <= 3'd0;
      flushed_q    <= 1'b0;
      int_ack_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      if (redirect) begin
        pc_q <= target;
      end else if (!bus.stall) begin
        pc_q <= pc_q + 32'd4;
      end
      cnt_q        <= cnt_d;
      flushed_q    <= (cnt_d != 3'd0);
      int_ack_q    <= (bus.pc_sel == 3'b100);
      misaligned_q <= misaligned_q | (redirect & target[1]);
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + 32'd4;
  assign bus.flushed    = flushed_q;
  assign bus.int_ack    = int_ack_q;
  assign bus.misaligned = misaligned_q;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Program-counter and redirect controller for the pipelined RV32I MCU. It is the consumer of the 3-bit PC_SEL produced by the branch-condition logic in EX.
- Selects the next fetch address, holds the PC on stalls, and produces the registered FLUSHED signal that squashes wrong-path instructions.
- FLUSHED is fed back to the branch-condition logic so that a squashed control-flow instruction can never redirect.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_DEPTH, 2, number of non-stalled cycles FLUSHED stays high after a redirect (range 1..7).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PC_SEL  in  3  next-PC select from EX: 000 seq, 001 jalr, 010 branch, 011 jal, 100 trap/mtvec, 101 mret/mepc; 110 and 111 are treated as 000.
- STALL  in  1  hazard stall; holds PC when no redirect is pending.
- JALR_TGT  in  32  rs1+imm from EX.
- BRANCH_TGT  in  32  EX_PC+B-imm.
- JAL_TGT  in  32  EX_PC+J-imm.
- MTVEC  in  32  trap vector from CSR.
- MEPC  in  32  return address from CSR.
- PC  out  32  current fetch address, registered.
- PC_PLUS4  out  32  PC+4, combinational, wraps modulo 2^32.
- FLUSHED  out  1  squash indicator, registered.
- INT_ACK  out  1  one-cycle pulse, registered, after a trap redirect.
- MISALIGNED  out  1  sticky flag: redirect target had bit1 set.

Behaviour:
- Reset (RST_N=0, async): PC=RESET_VEC, FLUSHED=0, INT_ACK=0, MISALIGNED=0, flush counter=0. Release is synchronous to the next CLK edge; the first fetch is RESET_VEC.
- Redirect = PC_SEL in {001,010,011,100,101}. Target mux:
  - 001: {JALR_TGT[31:1],1'b0} (bit0 cleared per RV spec).
  - 010: BRANCH_TGT. 011: JAL_TGT. 100: MTVEC. 101: MEPC.
- PC update each rising edge, in priority order:
  1. Redirect: PC <= target, regardless of STALL.
  2. STALL=1: PC holds.
  3. Otherwise: PC <= PC+4.
- Latency: PC_SEL sampled at edge t → PC equals target in cycle t+1 (one cycle).
- Flush counter (3 bits):
  - On a redirect edge, loads FLUSH_DEPTH (reload even if already nonzero).
  - Otherwise decrements when nonzero and STALL=0; holds when STALL=1.
  - FLUSHED = (counter != 0), driven from a flop; counter and FLUSHED update on the same edge.
  - Result: FLUSHED is high cycles t+1..t+FLUSH_DEPTH when there are no stalls; stalls extend the window one cycle each.
- Redirect while FLUSHED=1:
  - Upstream normally suppresses 001/010/011 while flushed; 100 (trap) may still arrive.
  - Any redirect arriving here is honoured: PC <= target, counter reloaded.
- INT_ACK <= (PC_SEL==100) every edge: a one-cycle pulse aligned with PC==MTVEC. Back-to-back traps give consecutive pulses.
- MISALIGNED: set on a redirect edge when target[1]==1 (target after the jalr bit0 clear). It stays set until reset; PC still loads the target unmodified.
- No other state exists. No outputs toggle during reset. Reset asserted mid-flush clears the counter immediately.

Test Plan:
1. Reset, RESET_VEC=0, PC_SEL=000, STALL=0 for 4 cycles → PC = 0,4,8,C; FLUSHED=0; PC_PLUS4 = PC+4.
2. PC=0x10, PC_SEL=010 for one cycle, BRANCH_TGT=0x80 → next cycle PC=0x80 and FLUSHED=1 for exactly 2 cycles. Then PC=0x84,0x88 with FLUSHED 1,0.
3. Branch redirect to 0x40 with STALL=1 in the following cycle → PC=0x40, holds 0x40 for one cycle; FLUSHED high 3 cycles total.
4. PC_SEL=001, JALR_TGT=0x103 → PC=0x102, MISALIGNED=1 (sticky); PC_SEL=011, JAL_TGT=0x200 → PC=0x200, MISALIGNED stays 1.
5. Branch redirect, then PC_SEL=100 (MTVEC=0x1000) in the first flushed cycle → PC=0x1000, INT_ACK pulses 1 cycle, FLUSHED reloaded (2 more cycles). Later PC_SEL=101, MEPC=0x84 → PC=0x84.
6. Drop RST_N asynchronously mid-flush with PC=0x300 → PC=0, FLUSHED=0, MISALIGNED=0 before the next CLK edge. PC_SEL=111 → treated as sequential (PC+4), no flush. PC=0xFFFF_FFFC sequential → PC wraps to 0x0.
